cpu_program_loader: RTL



---
 rtl/cpu_program_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cpu_program_loader.sv
// cpu_program_loader: takes a 32-bit host word stream and writes it into the
// instruction and data memories through their external write ports. Once both
// memories are loaded it raises enable for a programmed number of cycles,
// then reports completion.
module cpu_program_loader #(
    parameter int IMEM_WORDS_MAX = 128,
    parameter int DMEM_WORDS_MAX = 128,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [7:0]        imem_words,
    input  logic [7:0]        dmem_words,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic [63:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [31:0]       wdata_ext,
    output logic [63:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [63:0]       wdata_ext_2,
    output logic              enable,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        GAP,
        RUN,
        DONE
    } state_t;

    // Count inputs are only 8 bits wide, so the memory depths are clipped to
    // what an 8-bit count can express before being used as saturation limits.
    localparam logic [7:0] IMEM_LIMIT = (IMEM_WORDS_MAX > 255) ? 8'd255 : 8'(IMEM_WORDS_MAX);
    localparam logic [7:0] DMEM_LIMIT = (DMEM_WORDS_MAX > 255) ? 8'd255 : 8'(DMEM_WORDS_MAX);

    state_t             state;
    logic [7:0]         imem_cnt;
    logic [7:0]         dmem_cnt;
    logic [7:0]         i_idx;
    logic [7:0]         d_idx;
    logic               high_half;
    logic [31:0]        low_word;
    logic [CNT_W-1:0]   run_cnt;

    logic [7:0]         imem_sat;
    logic [7:0]         dmem_sat;
    logic [CNT_W-1:0]   cycle_next;
    logic               accept;

    assign imem_sat   = (imem_words > IMEM_LIMIT) ? IMEM_LIMIT : imem_words;
    assign dmem_sat   = (dmem_words > DMEM_LIMIT) ? DMEM_LIMIT : dmem_words;
    assign cycle_next = cycle_count + CNT_W'(1);

    assign s_ready   = (state == LOAD_I) || (state == LOAD_D);
    assign accept    = s_valid && s_ready;
    assign ren_ext   = 1'b0;
    assign ren_ext_2 = 1'b0;

    // Sequencer: latches the job on start, turns accepted beats into one-cycle
    // write pulses, then times the run window and flags completion.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            imem_cnt    <= '0;
            dmem_cnt    <= '0;
            i_idx       <= '0;
            d_idx       <= '0;
            high_half   <= 1'b0;
            low_word    <= '0;
            run_cnt     <= '0;
            addr_ext    <= '0;
            wen_ext     <= 1'b0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wen_ext_2   <= 1'b0;
            wdata_ext_2 <= '0;
            enable      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        imem_cnt    <= imem_sat;
                        dmem_cnt    <= dmem_sat;
                        run_cnt     <= run_cycles;
                        i_idx       <= '0;
                        d_idx       <= '0;
                        high_half   <= 1'b0;
                        done        <= 1'b0;
                        cycle_count <= '0;
                        busy        <= 1'b1;
                        if (imem_sat != 8'd0) begin
                            state <= LOAD_I;
                        end else if (dmem_sat != 8'd0) begin
                            state <= LOAD_D;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                LOAD_I: begin
                    if (accept) begin
                        wen_ext   <= 1'b1;
                        addr_ext  <= {54'd0, i_idx, 2'b00};
                        wdata_ext <= s_data;
                        if (i_idx == imem_cnt - 8'd1) begin
                            if (dmem_cnt != 8'd0) begin
                                state <= LOAD_D;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            i_idx <= i_idx + 8'd1;
                        end
                    end
                end
                LOAD_D: begin
                    if (accept) begin
                        if (!high_half) begin
                            low_word  <= s_data;
                            high_half <= 1'b1;
                        end else begin
                            high_half   <= 1'b0;
                            wen_ext_2   <= 1'b1;
                            addr_ext_2  <= {53'd0, d_idx, 3'b000};
                            wdata_ext_2 <= {s_data, low_word};
                            if (d_idx == dmem_cnt - 8'd1) begin
                                state <= GAP;
                            end else begin
                                d_idx <= d_idx + 8'd1;
                            end
                        end
                    end
                end
                GAP: begin
                    if (run_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state  <= RUN;
                        enable <= 1'b1;
                    end
                end
                RUN: begin
                    cycle_count <= cycle_next;
                    if (cycle_next == run_cnt) begin
                        state  <= DONE;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
